dht11_responder: RTL and testbench
==================================

Name: dht11_responder

Overview:
- Emulates the DHT11 sensor end of the single-wire bus, so the host-side reader can be exercised on the board without a physical sensor.
- Waits for a host start pulse, answers with the 80us low / 80us high presence handshake, then sends a 40-bit frame: humidity, temperature, checksum.
- Bit encoding is by pulse width.
- Sits beside the reader on the same pin: loopback between two FPGA pins, or a second board.

Parameters:
- CLK_PER_US, 50, clock cycles per microsecond (50 MHz board clock).
- START_MIN_US, 18000, minimum host low time accepted as a valid start.
- START_MAX_US, 30000, host low longer than this is treated as a bus fault.
- RESP_DELAY_US, 30, wait after host releases the bus before pulling low.
- T_LOW_US, 50, low preamble before each data bit and as end marker.
- T_ZERO_US, 26, released (high) time encoding a 0.
- T_ONE_US, 70, released (high) time encoding a 1.
- T_SYNC_US, 80, length of the presence low and of the presence high.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- dht_bus  inout  1  open-drain bus; the block only drives 0 or releases to Z (external pull-up).
- enable  in  1  1 = respond to host starts.
- humidity  in  16  {integer, decimal} bytes to report.
- temperature  in  16  {integer, decimal} bytes to report.
- busy  out  1  high from valid start detection until the frame ends.
- done  out  1  one-cycle pulse after the end marker completes.
- start_err  out  1  one-cycle pulse on a too-short or too-long host low.
- db_estado  out  4  current state encoding for the debug display.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; bus released.
  - busy=0, done=0, start_err=0.
  - Timer and bit counter cleared; frame register = 0.
  - Asserting reset mid-frame releases the bus in the same instant.
- Bus input:
  - 2-FF synchronizer, then falling/rising edge detect.
  - Edge and level decisions use only the synchronized value, so 2 cycles of latency.
- Timer:
  - Single cycle counter of width $clog2(START_MAX_US*CLK_PER_US)+1, cleared on every state change.
  - Phase end condition: timer == N*CLK_PER_US-1.
- Frame:
  - Latched when HOST_LOW ends validly: {humidity[15:8], humidity[7:0], temperature[15:8], temperature[7:0], chk}.
  - chk = 8-bit sum of the four bytes, carry discarded (e.g. 0xFF+0x01+0x00+0x00 = 0x00).
  - Transmitted MSB first; bit counter counts 39 down to 0.
  - Input changes during a frame do not affect it.
- States and transitions:
  - IDLE: bus released. On synchronized falling edge with enable=1 -> HOST_LOW. With enable=0, ignore edges.
  - HOST_LOW: count while bus low.
    - Rising edge with timer < START_MIN cycles -> IDLE, pulse start_err.
    - Rising edge at or above START_MIN -> latch frame, busy=1 -> RESP_DELAY.
    - Timer reaches START_MAX -> pulse start_err -> WAIT_RELEASE.
  - WAIT_RELEASE: bus released; on bus high -> IDLE.
  - RESP_DELAY: released for RESP_DELAY_US -> SYNC_LOW.
  - SYNC_LOW: drive 0 for T_SYNC_US -> SYNC_HIGH.
  - SYNC_HIGH: release for T_SYNC_US -> BIT_LOW.
  - BIT_LOW: drive 0 for T_LOW_US -> BIT_HIGH.
  - BIT_HIGH: release for T_ONE_US if the current bit = 1, else T_ZERO_US.
    - Bit counter = 0 -> END_LOW.
    - Otherwise decrement -> BIT_LOW.
  - END_LOW: drive 0 for T_LOW_US -> FINISH.
  - FINISH: release; busy=0; done=1 for one cycle -> IDLE.
- The block never reacts to host activity while busy. Bus contention is the host's fault and is ignored.
- Deasserting enable mid-frame: the frame completes; enable is only sampled in IDLE.
- A falling edge arriving in the same cycle as FINISH is not captured; the host must wait until the bus is idle.
- Open-drain contract:
  - dht_bus = drive_low ? 0 : Z.
  - drive_low is registered, so there are no glitches on the pin.

Decomposition:
- Shared package dht11_pkg:
  - State encoding localparams, also used by the reader's db_estado decode.
  - DHT11 nominal timing constants in microseconds.
  - FRAME_BITS=40.
  - Checksum function (8-bit byte sum).
- One sub-module, dht11_bus_sync: 2-FF synchronizer plus rise/fall edge pulses. Reusable by the reader.

Test Plan:
- Host drives low 18ms, then releases (pull-up modelled):
  - Bus stays high 30us, then 80us low, then 80us high.
  - Measured within ±1 cycle + 2 sync cycles.
- humidity=0x3700, temperature=0x1A05:
  - Decoded frame is 0x37,0x00,0x1A,0x05,0x56.
  - Each 1 bit has a 70us high; each 0 bit has a 26us high.
  - Final 50us low, then done pulses exactly once.
- Checksum wrap: humidity=0xFF01, temperature=0x0000 -> checksum byte 0x00.
- Host low of 5ms -> start_err pulse, no bus drive, busy stays 0. A following 18ms start is answered normally.
- Host low of 35ms -> start_err pulse at 30ms, no response. The block returns to IDLE after the bus goes high.
- Reset and input checks during a frame:
  - Assert reset_n low during bit 20 -> bus released immediately, busy=0. After release, a new 18ms start gets a full response.
  - Change humidity mid-frame -> transmitted bytes are unchanged.

Source files
------------

// File: rtl/dht11_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dht11_pkg
// Brief    : Shared DHT11 definitions: state codes for the debug display,
//            nominal bus timing in microseconds, frame size and checksum.
// Revision : 1.0  initial release
// ============================================================================
package dht11_pkg;

    // State codes shown on db_estado; the reader decodes the same values
    localparam logic [3:0] ST_IDLE         = 4'd0;
    localparam logic [3:0] ST_HOST_LOW     = 4'd1;
    localparam logic [3:0] ST_WAIT_RELEASE = 4'd2;
    localparam logic [3:0] ST_RESP_DELAY   = 4'd3;
    localparam logic [3:0] ST_SYNC_LOW     = 4'd4;
    localparam logic [3:0] ST_SYNC_HIGH    = 4'd5;
    localparam logic [3:0] ST_BIT_LOW      = 4'd6;
    localparam logic [3:0] ST_BIT_HIGH     = 4'd7;
    localparam logic [3:0] ST_END_LOW      = 4'd8;
    localparam logic [3:0] ST_FINISH       = 4'd9;

    typedef enum logic [3:0] {
        S_IDLE         = ST_IDLE,
        S_HOST_LOW     = ST_HOST_LOW,
        S_WAIT_RELEASE = ST_WAIT_RELEASE,
        S_RESP_DELAY   = ST_RESP_DELAY,
        S_SYNC_LOW     = ST_SYNC_LOW,
        S_SYNC_HIGH    = ST_SYNC_HIGH,
        S_BIT_LOW      = ST_BIT_LOW,
        S_BIT_HIGH     = ST_BIT_HIGH,
        S_END_LOW      = ST_END_LOW,
        S_FINISH       = ST_FINISH
    } dht11_state_t;

    // Nominal DHT11 timing, microseconds
    localparam int DHT_CLK_PER_US    = 50;
    localparam int DHT_START_MIN_US  = 18000;
    localparam int DHT_START_MAX_US  = 30000;
    localparam int DHT_RESP_DELAY_US = 30;
    localparam int DHT_T_LOW_US      = 50;
    localparam int DHT_T_ZERO_US     = 26;
    localparam int DHT_T_ONE_US      = 70;
    localparam int DHT_T_SYNC_US     = 80;

    localparam int FRAME_BITS = 40;

    // 8-bit sum of the four payload bytes; the carry falls off naturally
    function automatic logic [7:0] dht11_checksum(input logic [31:0] data);
        logic [7:0] sum;
        sum = data[31:24] + data[23:16] + data[15:8] + data[7:0];
        return sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dht11_bus_sync.sv
`default_nettype none
// ============================================================================
// Module   : dht11_bus_sync
// Brief    : Two-flop synchronizer for the single-wire bus plus rise/fall
//            pulses derived from the synchronized level.
// Revision : 1.0  initial release
// ============================================================================
module dht11_bus_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic bus_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Resync the pin and keep one delayed copy for edge detection; reset to
    // the idle (pulled-up) level so no edge appears on reset release
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= bus_in;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;

endmodule
`default_nettype wire

// File: rtl/dht11_responder.sv
`default_nettype none
// ============================================================================
// Module   : dht11_responder
// Brief    : DHT11 sensor emulator. Detects a host start pulse, answers with
//            the presence handshake and sends humidity, temperature and
//            checksum as pulse-width-encoded bits on an open-drain pin.
// Revision : 1.0  initial release
// ============================================================================
module dht11_responder
    import dht11_pkg::*;
#(
    parameter int CLK_PER_US    = DHT_CLK_PER_US,
    parameter int START_MIN_US  = DHT_START_MIN_US,
    parameter int START_MAX_US  = DHT_START_MAX_US,
    parameter int RESP_DELAY_US = DHT_RESP_DELAY_US,
    parameter int T_LOW_US      = DHT_T_LOW_US,
    parameter int T_ZERO_US     = DHT_T_ZERO_US,
    parameter int T_ONE_US      = DHT_T_ONE_US,
    parameter int T_SYNC_US     = DHT_T_SYNC_US
) (
    input  logic        clock,
    input  logic        reset_n,
    inout  wire         dht_bus,
    input  logic        enable,
    input  logic [15:0] humidity,
    input  logic [15:0] temperature,
    output logic        busy,
    output logic        done,
    output logic        start_err,
    output logic [3:0]  db_estado
);

    localparam int TW = $clog2(START_MAX_US * CLK_PER_US) + 1;

    // Start window bounds and last-cycle values of each timed phase
    localparam logic [TW-1:0] START_MIN_CYC = TW'(START_MIN_US * CLK_PER_US);
    localparam logic [TW-1:0] START_MAX_END = TW'(START_MAX_US * CLK_PER_US - 1);
    localparam logic [TW-1:0] RESP_END      = TW'(RESP_DELAY_US * CLK_PER_US - 1);
    localparam logic [TW-1:0] SYNC_END      = TW'(T_SYNC_US * CLK_PER_US - 1);
    localparam logic [TW-1:0] LOW_END       = TW'(T_LOW_US * CLK_PER_US - 1);
    localparam logic [TW-1:0] ZERO_END      = TW'(T_ZERO_US * CLK_PER_US - 1);
    localparam logic [TW-1:0] ONE_END       = TW'(T_ONE_US * CLK_PER_US - 1);

    dht11_state_t            state;
    logic [TW-1:0]           timer;
    logic [5:0]              bit_cnt;
    logic [FRAME_BITS-1:0]   frame;
    logic                    drive_low;

    logic bus_level;
    logic bus_rise;
    logic bus_fall;

    dht11_bus_sync u_bus_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .bus_in  (dht_bus),
        .level   (bus_level),
        .rise    (bus_rise),
        .fall    (bus_fall)
    );

    // Open drain: only ever pull low; the register keeps the pin glitch-free
    // and reset clears it asynchronously so the bus is freed at once
    assign dht_bus   = drive_low ? 1'b0 : 1'bz;
    assign db_estado = state;

    // Protocol sequencer: phase timing, frame shifting and status pulses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            timer     <= '0;
            bit_cnt   <= '0;
            frame     <= '0;
            drive_low <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            start_err <= 1'b0;
        end else begin
            done      <= 1'b0;
            start_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    timer <= '0;
                    if (bus_fall && enable) begin
                        state <= S_HOST_LOW;
                    end
                end

                S_HOST_LOW: begin
                    if (bus_rise) begin
                        timer <= '0;
                        if (timer < START_MIN_CYC) begin
                            start_err <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            // Snapshot the payload so later input changes
                            // cannot corrupt the frame in flight
                            frame   <= {humidity, temperature,
                                        dht11_checksum({humidity, temperature})};
                            bit_cnt <= 6'(FRAME_BITS - 1);
                            busy    <= 1'b1;
                            state   <= S_RESP_DELAY;
                        end
                    end else if (timer == START_MAX_END) begin
                        timer     <= '0;
                        start_err <= 1'b1;
                        state     <= S_WAIT_RELEASE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_WAIT_RELEASE: begin
                    timer <= '0;
                    if (bus_level) begin
                        state <= S_IDLE;
                    end
                end

                S_RESP_DELAY: begin
                    if (timer == RESP_END) begin
                        timer     <= '0;
                        drive_low <= 1'b1;
                        state     <= S_SYNC_LOW;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_SYNC_LOW: begin
                    if (timer == SYNC_END) begin
                        timer     <= '0;
                        drive_low <= 1'b0;
                        state     <= S_SYNC_HIGH;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_SYNC_HIGH: begin
                    if (timer == SYNC_END) begin
                        timer     <= '0;
                        drive_low <= 1'b1;
                        state     <= S_BIT_LOW;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_BIT_LOW: begin
                    if (timer == LOW_END) begin
                        timer     <= '0;
                        drive_low <= 1'b0;
                        state     <= S_BIT_HIGH;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_BIT_HIGH: begin
                    // High time encodes the bit value, MSB first
                    if (timer == (frame[bit_cnt] ? ONE_END : ZERO_END)) begin
                        timer     <= '0;
                        drive_low <= 1'b1;
                        if (bit_cnt == 6'd0) begin
                            state <= S_END_LOW;
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                            state   <= S_BIT_LOW;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_END_LOW: begin
                    if (timer == LOW_END) begin
                        timer     <= '0;
                        drive_low <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_FINISH;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_FINISH: begin
                    timer <= '0;
                    state <= S_IDLE;
                end

                default: begin
                    timer     <= '0;
                    drive_low <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dht11_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dht11_responder
// Brief    : Self-checking bench for dht11_responder. A host model drives
//            start pulses on a pulled-up bus; a bus monitor records pulse
//            widths which are decoded and compared with frames computed from
//            the sensor protocol rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_dht11_responder;
    import dht11_pkg::*;

    // Scaled start window keeps runs short; bit timing is nominal
    localparam int C        = 2;
    localparam int MIN_US   = 180;
    localparam int MAX_US   = 300;
    localparam int RESP_US  = 30;
    localparam int LOW_US   = 50;
    localparam int ZERO_US  = 26;
    localparam int ONE_US   = 70;
    localparam int SYNC_US  = 80;
    localparam int FRAME_LIMIT = 6000 * C;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [15:0] humidity;
    logic [15:0] temperature;
    logic        busy;
    logic        done;
    logic        start_err;
    logic [3:0]  db_estado;
    logic        host_low;
    wire         dht_bus;

    assign dht_bus = host_low ? 1'b0 : 1'bz;
    pullup (dht_bus);

    dht11_responder #(
        .CLK_PER_US    (C),
        .START_MIN_US  (MIN_US),
        .START_MAX_US  (MAX_US),
        .RESP_DELAY_US (RESP_US),
        .T_LOW_US      (LOW_US),
        .T_ZERO_US     (ZERO_US),
        .T_ONE_US      (ONE_US),
        .T_SYNC_US     (SYNC_US)
    ) dut (
        .clock       (clk),
        .reset_n     (reset_n),
        .dht_bus     (dht_bus),
        .enable      (enable),
        .humidity    (humidity),
        .temperature (temperature),
        .busy        (busy),
        .done        (done),
        .start_err   (start_err),
        .db_estado   (db_estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- bus monitor ----------------
    int  seg_len[$];
    bit  seg_lvl[$];
    bit  mon_lvl = 1'b1;
    int  mon_run = 0;
    int  cyc = 0;
    int  done_cnt, err_cnt, busy_cnt, drv_cnt, err_cyc, fall_cyc;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if ((dht_bus === 1'b0) != (mon_lvl == 1'b0)) begin
                seg_lvl.push_back(mon_lvl);
                seg_len.push_back(mon_run);
                mon_lvl = (dht_bus !== 1'b0);
                mon_run = 1;
            end else begin
                mon_run++;
            end
            if (done === 1'b1)      done_cnt++;
            if (start_err === 1'b1) begin err_cnt++; err_cyc = cyc; end
            if (busy === 1'b1)      busy_cnt++;
            if (!host_low && dht_bus === 1'b0) drv_cnt++;
        end
    end

    task automatic clear_mon();
        seg_len.delete();
        seg_lvl.delete();
        done_cnt = 0; err_cnt = 0; busy_cnt = 0; drv_cnt = 0; err_cyc = 0;
    endtask

    task automatic host_down();
        @(posedge clk);
        host_low = 1'b1;
        fall_cyc = cyc;
    endtask

    task automatic host_pulse(input int us);
        host_down();
        repeat (us * C) @(posedge clk);
        host_low = 1'b0;
    endtask

    // Reference frame: payload bytes followed by their byte sum modulo 256
    function automatic logic [39:0] model_frame(input logic [15:0] h, input logic [15:0] t);
        int s;
        s = (int'(h[15:8]) + int'(h[7:0]) + int'(t[15:8]) + int'(t[7:0])) % 256;
        return {h, t, s[7:0]};
    endfunction

    // One full transaction: start, scramble inputs mid-frame, decode pulses
    task automatic run_frame(input logic [15:0] h, input logic [15:0] t, input int low_us);
        logic [39:0] exp_frame;
        logic [39:0] got;
        int n, base, bad, hi, lo;
        bit b;
        humidity    = h;
        temperature = t;
        exp_frame   = model_frame(h, t);
        clear_mon();
        host_pulse(low_us);
        repeat (1000) @(posedge clk);
        humidity    = 16'($urandom);
        temperature = 16'($urandom);
        for (int i = 0; i < FRAME_LIMIT && done_cnt == 0; i++) @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("done_once", done_cnt, 1);
        check("no_start_err", err_cnt, 0);
        check("busy_seen", busy_cnt > 0, 1);
        check("busy_clear", busy, 1'b0);
        n = seg_len.size();
        check("seg_count", n >= 85, 1);
        if (n >= 85) begin
            base = n - 84;
            check("host_low_seg", seg_lvl[base-1], 1'b0);
            check("resp_delay", (seg_len[base] >= RESP_US*C) && (seg_len[base] <= RESP_US*C + 4), 1);
            check("sync_low", seg_len[base+1], SYNC_US*C);
            check("sync_high", seg_len[base+2], SYNC_US*C);
            bad = 0;
            got = '0;
            for (int k = 0; k < 40; k++) begin
                lo = seg_len[base + 3 + 2*k];
                hi = seg_len[base + 4 + 2*k];
                if (lo != LOW_US*C) bad++;
                b = (hi > ((ZERO_US + ONE_US) / 2) * C);
                got = {got[38:0], b};
                if (hi != (b ? ONE_US : ZERO_US) * C) bad++;
            end
            check("bit_widths", bad, 0);
            check("frame", got, exp_frame);
            check("end_low", seg_len[base+83], LOW_US*C);
        end
    endtask

    task automatic expect_quiet(input string tag, input int exp_err);
        repeat ((RESP_US + 2*SYNC_US + 50) * C) @(posedge clk);
        @(negedge clk);
        check({tag, "_err"}, err_cnt, exp_err);
        check({tag, "_nodrive"}, drv_cnt, 0);
        check({tag, "_nobusy"}, busy_cnt, 0);
        check({tag, "_idle"}, db_estado, ST_IDLE);
    endtask

    initial begin
        int falls;
        bit prev;
        reset_n     = 1'b0;
        enable      = 1'b1;
        humidity    = '0;
        temperature = '0;
        host_low    = 1'b0;
        done_cnt = 0; err_cnt = 0; busy_cnt = 0; drv_cnt = 0; err_cyc = 0; fall_cyc = 0;
        repeat (4) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", start_err, 1'b0);
        check("rst_state", db_estado, ST_IDLE);
        check("rst_bus", dht_bus, 1'b1);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Directed payload, then checksum wraparound
        run_frame(16'h3700, 16'h1A05, 190);
        run_frame(16'hFF01, 16'h0000, 200);

        // Too-short start: error, no reply; then a normal start
        clear_mon();
        host_pulse(50);
        expect_quiet("short", 1);
        run_frame(16'($urandom), 16'($urandom), 185);

        // Too-long start: error near the max window, no reply, back to idle
        clear_mon();
        host_down();
        repeat (350 * C) @(posedge clk);
        @(negedge clk);
        check("long_wait_state", db_estado, ST_WAIT_RELEASE);
        check("long_err_time", (err_cyc - fall_cyc >= MAX_US*C + 1) && (err_cyc - fall_cyc <= MAX_US*C + 6), 1);
        @(posedge clk);
        host_low = 1'b0;
        expect_quiet("long", 1);

        // Disabled: a valid start is ignored
        enable = 1'b0;
        clear_mon();
        host_pulse(200);
        expect_quiet("disabled", 0);
        enable = 1'b1;

        // Reset during bit 20 frees the bus immediately
        humidity    = 16'h0000;
        temperature = 16'h0000;
        clear_mon();
        host_pulse(200);
        falls = 0;
        prev  = 1'b1;
        for (int i = 0; i < FRAME_LIMIT && falls < 22; i++) begin
            @(negedge clk);
            if (prev && dht_bus === 1'b0) falls++;
            prev = (dht_bus !== 1'b0);
        end
        check("bit20_reached", falls, 22);
        repeat (10) @(negedge clk);
        check("bit20_low", dht_bus === 1'b0, 1);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_bus", dht_bus === 1'b1, 1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_state", db_estado, ST_IDLE);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        run_frame(16'($urandom), 16'($urandom), 220);

        // Random payloads and start lengths
        for (int r = 0; r < 2; r++) begin
            run_frame(16'($urandom), 16'($urandom), int'($urandom_range(190, 280)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
